// File: rtl/mux_n_rr_pkg.sv
// Shared types and helpers for the round-robin channel merger and its arbiters.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_rr_if.sv
// Producer/consumer bundle for mux_n_rr; slave is the mux side, master the environment.
interface mux_n_rr_if
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) ();

  localparam int IW = clog2_min1(N);

  mux_mode_t          mode;
  logic [IW-1:0]      sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [IW-1:0]      out_chan;
  logic               out_valid;
  logic               out_ready;
`ifdef MUX_PARITY_EN
  logic               out_parity;
`endif

  modport slave (
`ifdef MUX_PARITY_EN
    output out_parity,
`endif
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
`ifdef MUX_PARITY_EN
    input  out_parity,
`endif
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

endinterface

// File: rtl/mux_n_rr_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          grant_valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path infers a latch.
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      automatic int idx = (int'(ptr) + k) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_n_rr.sv
// N-channel flow-controlled merger with a registered output stage, fixed or round-robin select.
// Define MUX_PARITY_EN to add a registered even-parity bit alongside out_data.
module mux_n_rr
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      reset,
  mux_n_rr_if.slave bus
);

  localparam int            IW      = clog2_min1(N);
  localparam logic [IW-1:0] PTR_RST = IW'(N - 1);

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    chan_q, chan_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
`ifdef MUX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [IW-1:0]    rr_grant, grant;
  logic             rr_valid, grant_valid;
  logic             load;
  logic [WIDTH-1:0] grant_data;
  logic [N-1:0]     in_ready;

  rr_pick #(.N(N), .IW(IW)) u_rr_pick (
    .req         (bus.in_valid),
    .ptr         (ptr_q),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  // sel values past N-1 (non-power-of-two N) never grant.
  always_comb begin
    grant       = rr_grant;
    grant_valid = rr_valid;
    if (bus.mode == MODE_FIXED) begin
      grant       = bus.sel;
      grant_valid = (int'(bus.sel) < N) && bus.in_valid[bus.sel];
    end
  end

  assign load       = !valid_q || bus.out_ready;
  assign grant_data = bus.in_data[grant*WIDTH +: WIDTH];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = reset && load && grant_valid && (int'(grant) == i);
    end
  end

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    chan_d   = chan_q;
    ptr_d    = ptr_q;
`ifdef MUX_PARITY_EN
    parity_d = parity_q;
`endif
    if (load) begin
      valid_d = grant_valid;
      if (grant_valid) begin
        data_d = grant_data;
        chan_d = grant;
`ifdef MUX_PARITY_EN
        parity_d = ^grant_data;
`endif
        if (bus.mode == MODE_RR) ptr_d = grant;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      chan_q   <= '0;
      ptr_q    <= PTR_RST;
`ifdef MUX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      chan_q   <= chan_d;
      ptr_q    <= ptr_d;
`ifdef MUX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
`ifdef MUX_PARITY_EN
  assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_n_rr.sv
// Directed bench for mux_n_rr: stimulus pushes expected words, a monitor pops them on output handshakes.
module tb_mux_n_rr;
  import mux_pkg::*;

  typedef struct {
    logic [1:0] chan;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   pass_cnt  = 0;
  int   check_cnt = 0;
  exp_t sb_q[$];

  mux_n_rr_if #(.N(4), .WIDTH(8)) bus ();

  mux_n_rr #(.N(4), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic expect_word(input logic [1:0] c, input logic [7:0] d);
    exp_t e;
    e.chan = c;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    bus.in_data = {d3, d2, d1, d0};
  endtask

  // One cycle: check in_ready mid-cycle, then advance to just after the next rising edge.
  task automatic step_ready(input logic [3:0] exp_rdy, input string name);
    @(negedge clk);
    check(name, 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    repeat (2) step_ready(4'b0000, "drain_in_ready");
  endtask

  // Scoreboard monitor: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_word", 32'(bus.out_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_chan", 32'(bus.out_chan), 32'(e.chan));
        check("out_data", 32'(bus.out_data), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] seq_b[4];
    reset         = 1'b0;
    bus.mode      = MODE_FIXED;
    bus.sel       = 2'd0;
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b0;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);

    // Reset held, then idle
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_out_data",  32'(bus.out_data),  32'h0);
      check("rst_out_chan",  32'(bus.out_chan),  32'h0);
      check("rst_in_ready",  32'(bus.in_ready),  32'h0);
`ifdef MUX_PARITY_EN
      check("rst_out_parity", 32'(bus.out_parity), 32'h0);
`endif
    end
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_out_valid", 32'(bus.out_valid), 32'h0);
      check("idle_in_ready",  32'(bus.in_ready),  32'h0);
    end
    @(posedge clk);
    #1;

    // Fixed mode pass-through on channel 2
    bus.mode     = MODE_FIXED;
    bus.sel      = 2'd2;
    bus.in_valid = 4'b1111;
    set_data(8'h01, 8'h02, 8'hA5, 8'h04);
    repeat (3) begin
      expect_word(2'd2, 8'hA5);
      step_ready(4'b0100, "fixed_in_ready");
    end
    drain();

    // Round-robin over all four channels, starting at channel 0
    bus.mode     = MODE_RR;
    bus.in_valid = 4'b1111;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] c;
      c = 2'(i % 4);
      expect_word(c, 8'h10 + 8'(c));
      step_ready(4'(1 << c), "rr_in_ready");
    end
    drain();

    // Round-robin skip and wrap with channels 1 and 3 only
    seq_b = '{2'd1, 2'd3, 2'd1, 2'd3};
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      expect_word(seq_b[i], 8'h10 + 8'(seq_b[i]));
      step_ready(4'(1 << seq_b[i]), "rr_skip_in_ready");
    end
    drain();

    // Backpressure: hold 0x3C for three cycles, then drain and load with no bubble
    bus.mode     = MODE_FIXED;
    bus.sel      = 2'd0;
    bus.in_valid = 4'b0001;
    set_data(8'h3C, 8'h11, 8'h12, 8'h13);
    expect_word(2'd0, 8'h3C);
    step_ready(4'b0001, "bp_load_in_ready");
    set_data(8'h5A, 8'h11, 8'h12, 8'h13);
    bus.out_ready = 1'b0;
    expect_word(2'd0, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'h1);
      check("bp_out_data",  32'(bus.out_data),  32'h3C);
      check("bp_in_ready",  32'(bus.in_ready),  32'h0);
      @(posedge clk);
      #1;
      if (i == 0) bus.mode = MODE_RR;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 4'b0000;
    @(negedge clk);
    check("bp_nobubble_valid", 32'(bus.out_valid), 32'h1);
    check("bp_nobubble_data",  32'(bus.out_data),  32'h5A);
    @(posedge clk);
    #1;
    drain();

    // Asynchronous reset while FULL, then round-robin restarts at channel 0
    bus.mode      = MODE_RR;
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b0;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    step_ready(4'b0100, "pre_rst_in_ready");
    bus.in_valid = 4'b1111;
    @(negedge clk);
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'h1);
    check("pre_rst_out_data",  32'(bus.out_data),  32'h12);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("async_rst_out_data",  32'(bus.out_data),  32'h0);
    check("async_rst_in_ready",  32'(bus.in_ready),  32'h0);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    expect_word(2'd0, 8'h10);
    step_ready(4'b0001, "post_rst_rr0");
    expect_word(2'd1, 8'h11);
    step_ready(4'b0010, "post_rst_rr1");
    drain();

`ifdef MUX_PARITY_EN
    // Parity of captured data
    bus.mode     = MODE_FIXED;
    bus.sel      = 2'd1;
    bus.in_valid = 4'b0010;
    set_data(8'h00, 8'h07, 8'h00, 8'h00);
    expect_word(2'd1, 8'h07);
    step_ready(4'b0010, "par_in_ready");
    set_data(8'h00, 8'h03, 8'h00, 8'h00);
    expect_word(2'd1, 8'h03);
    @(negedge clk);
    check("parity_07", 32'(bus.out_parity), 32'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 4'b0000;
    @(negedge clk);
    check("parity_03", 32'(bus.out_parity), 32'h0);
    @(posedge clk);
    #1;
    drain();
`endif

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/mux_n_rr.md
Name: mux_n_rr

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with a registered output stage and valid/ready handshakes on every input and on the output.
- Selection is either fixed, driven by the sel port, or fair round-robin among the valid channels.
- Generalises the single-bit 2:1 mux into a flow-controlled channel merger.
- Sits between several producers (switch/counter/sensor paths) and one consumer (display or shift logic).

Parameters:
N, 4, number of input channels (N >= 2)
WIDTH, 8, data width per channel (WIDTH >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mode  input  1  0 = fixed select via sel, 1 = round-robin
sel  input  $clog2(N)  channel index used in fixed mode
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel data valid
in_ready  output  N  per-channel accept; at most one bit high
out_data  output  WIDTH  registered selected data
out_chan  output  $clog2(N)  index of the channel that supplied out_data
out_valid  output  1  output register holds data
out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset (reset low, asynchronous):
  - out_valid=0, out_data=0, out_chan=0.
  - RR pointer ptr=N-1, so the first round-robin search starts at channel 0.
  - in_ready is all-zero while reset is held.
- Output register has two states, deduced from out_valid:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load enable: load = !out_valid || out_ready. This allows a full-throughput pass-through when the consumer is ready every cycle.
- Grant (combinational):
  - Fixed mode: grant = sel if in_valid[sel].
  - Fixed mode, sel >= N (non-power-of-2 N): no grant.
  - RR mode: first i with in_valid[i], scanning ptr+1, ptr+2, … modulo N. Wraps from N-1 to 0.
  - No valid candidate: no grant.
- in_ready[i] = load && grant_valid && grant==i. Combinational; no in_valid -> in_ready dependency loop across channels.
- Transfer in: on a clock edge with load && grant_valid:
  - out_data <= channel data, out_chan <= grant, out_valid <= 1.
  - Latency is one cycle from input handshake to out_valid.
- Drain:
  - load && !grant_valid -> out_valid <= 0.
  - FULL && !out_ready -> out_data, out_chan and out_valid hold, and every in_ready is 0.
- ptr update: ptr <= grant only on an input transfer in RR mode. Fixed-mode transfers leave ptr unchanged.
- Mode or sel change while FULL: the held output is unaffected. The new mode applies to the next grant.
- Simultaneous drain and load: the same edge both retires the old word and captures the new one. No bubble.
- Reset asserted mid-transfer: the held word is discarded and out_valid drops immediately (asynchronous).
- in_data of non-granted channels is ignored. Producers must hold data and valid until they see in_ready.

Optional Feature:
MUX_PARITY_EN
- Defined: adds output port out_parity (1 bit), registered alongside out_data.
  - Equals the even parity (XOR reduction) of the captured data.
  - Reset value 0.
  - Holds with out_data when stalled.
- Undefined: no out_parity port and no parity logic. All other behaviour is identical.

Decomposition:
- Package mux_pkg holds:
  - typedef mux_mode_t: MODE_FIXED=1'b0, MODE_RR=1'b1.
  - function clog2_min1(n), which returns at least 1 for index widths.
- One sub-module, rr_pick:
  - Combinational.
  - Inputs: request vector, pointer.
  - Outputs: grant index and grant_valid.
  - Reused by later arbiters.
- The output register and ptr live in mux_n_rr.

Test Plan:
- Reset then idle: reset low for 2 cycles then high, all in_valid=0 -> out_valid=0, out_data=0, in_ready=0000 on every cycle.
- Fixed mode pass-through: mode=0, sel=2, in_valid=1111, ch2=0xA5, out_ready=1.
  - One cycle later: out_valid=1, out_data=0xA5, out_chan=2.
  - in_ready=0100 on every cycle.
- Round-robin fairness: mode=1, all four valid with data 0x10,0x11,0x12,0x13, out_ready=1 -> out_chan sequence 0,1,2,3,0 with matching out_data, one word per cycle.
- Round-robin skip and wrap: mode=1, in_valid=1010 (channels 1 and 3) -> out_chan sequence 1,3,1,3; channels 0 and 2 never granted.
- Backpressure: FULL with out_data=0x3C, out_ready=0 for 3 cycles.
  - out_data stays 0x3C and in_ready=0000.
  - out_ready=1 -> next word loads on the same edge with no bubble.
- Asynchronous reset mid-stream: while FULL, pull reset low between clock edges -> out_valid=0 before the next edge. After release, RR restarts at channel 0.
- With MUX_PARITY_EN defined: data 0x07 -> out_parity=1; data 0x03 -> out_parity=0.
